seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed scanner for a multi-digit 7-segment display. Holds a latched multi-digit hex value and, one digit per time slot, drives the 4-bit nibble into the downstream seg7 hex decoder and the matching one-hot digit enable. It inserts a dead interval between digits against ghosting and optionally blanks leading zeros. It sits between the counter/datapath and seg7, which the top level instantiates separately.

## Interface
- DIGITS, 4: number of digits scanned; must be ≥2.
- DIV, 50000: clock cycles per digit slot; must be ≥2.
- DEAD, 500: cycles at the start of each slot with all digits off; 0 ≤ DEAD < DIV.

- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  4*DIGITS  value to display; digit k is data_i[4k+3:4k], and digit 0 is the rightmost.
- load_i  in  1  single-cycle strobe; captures data_i into the shadow register.
- blank_lz_i  in  1  1 = blank leading zero digits.
- dp_i  in  DIGITS  decimal-point request per digit.
- nibble_o  out  4  hex digit for seg7 data_i; registered.
- dig_o  out  DIGITS  one-hot active-high digit enable, or all zero; registered.
- dp_o  out  1  decimal point for the current digit; registered.

## Operation
- Registers:
  - slot counter cnt, range 0..DIV-1.
  - digit index idx, range 0..DIGITS-1.
  - shadow register shd (4*DIGITS bits), loaded from data_i.
  - display register dsp (4*DIGITS bits), the value actually scanned.
- State machine per slot:
  - DEAD: entered when cnt=0; all digits off.
  - SHOW: entered when cnt=DEAD; digit idx on.
  - With DEAD=0, the FSM never enters DEAD.
- cnt increments every cycle. At cnt=DIV-1 it wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
- load_i=1 sets shd ← data_i on the next edge, at any point in the frame.
- Frame boundary (cnt=DIV-1 and idx=DIGITS-1):
  - dsp ← shd.
  - If load_i=1 in the same cycle, dsp ← data_i and shd ← data_i (the new load wins).
  - This rule prevents tearing within a frame.
- Leading-zero blanking: digit k>0 is blanked when blank_lz_i=1 and dsp digits k..DIGITS-1 are all zero. Digit 0 is never blanked.
- Output register inputs, sampled each edge:
  - nibble_o ← dsp digit idx.
  - dp_o ← dp_i[idx] when in SHOW, otherwise 0.
  - dig_o ← one-hot(idx) when in SHOW and digit idx is not blanked, otherwise 0.
- A blanked digit still consumes its full slot; only dig_o stays 0.
- dp_i is applied live, without latching.

## Timing
- Reset values: cnt=0, idx=0, state DEAD, shd=0, dsp=0, nibble_o=0, dig_o=0, dp_o=0.
- Outputs lag (cnt, idx) by one cycle because they are registered.
- dig_o is asserted for exactly DIV-DEAD cycles per slot and is 0 for DEAD cycles.
- Frame period is DIGITS*DIV cycles.
- Latency from load_i to display:
  - New data appears at the start of the next frame: the first digit-0 slot after the next boundary.
  - Worst case is DIGITS*DIV+1 cycles.
- Simultaneous load_i and frame boundary: data_i is displayed in the very next frame.
- rst_i asserted mid-slot: on the next edge all registers take their reset values and dig_o=0. Scanning restarts at digit 0 with dsp=0.
- rst_i has priority over load_i.
- After reset release, digit 0 shows 0 (never blanked); digits 1..DIGITS-1 show 0 unless blank_lz_i=1.

## Structure
- Shared package seg_pkg holds:
  - DIV_DEFAULT and DEAD_DEFAULT constants.
  - The slot state enum {DEAD, SHOW}.
- No sub-module. Prescaler, FSM and blanking logic all live in seg_scan.
- seg7 stays a separate instance at top level, with nibble_o connected to seg7 data_i.

## Test plan
All scenarios use DIGITS=4, DIV=8, DEAD=2.
- Reset: hold rst_i 3 cycles → dig_o=0000, nibble_o=0, dp_o=0. After release, dig_o=0001 and nibble_o=0 for 6 cycles following 2 off cycles.
- Scan order: load 0x12A4, then wait for the boundary → per slot, 2 cycles dig_o=0000 then 6 cycles of 0001/4, 0010/A, 0100/2, 1000/1. Frame is 32 cycles, then it repeats.
- Blanking: load 0x0050 with blank_lz_i=1 → digit 0 shows 0, digit 1 shows 5, digits 2 and 3 have dig_o=0000 for their full slots. With blank_lz_i=0, all four digits are lit.
- Mid-frame load: display 0x1111, then load 0x2222 during idx=2 → digits 2 and 3 still show 1. The next frame shows all 2s.
- Boundary collision: assert load_i=0x3333 exactly at cnt=7, idx=3 → the next frame shows 3s. A preceding pending shd value is discarded.
- Reset mid-operation: assert rst_i during the SHOW of idx=2 → the next cycle has dig_o=0000, and after release digit 0 shows 0. dp_i=0100 is then seen on dp_o only during digit 2 SHOW cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and slot-state type for the 7-segment display scanner.
package seg_pkg;

  localparam int DIV_DEFAULT  = 50000;
  localparam int DEAD_DEFAULT = 500;

  typedef enum logic {
    SLOT_DEAD,
    SLOT_SHOW
  } slot_state_e;

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed digit scanner: one nibble + one-hot enable per slot, dead gap, leading-zero blanking.
// Outputs registered (one cycle behind cnt/idx); new loads show from the next frame, no backpressure.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV    = DIV_DEFAULT,
  parameter int DEAD   = DEAD_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [4*DIGITS-1:0] data_i,
  input  logic                load_i,
  input  logic                blank_lz_i,
  input  logic [DIGITS-1:0]   dp_i,
  output logic [3:0]          nibble_o,
  output logic [DIGITS-1:0]   dig_o,
  output logic                dp_o
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD == 0) ? 0 : DEAD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  // With no dead interval every slot opens directly in SHOW.
  localparam slot_state_e SLOT_START = (DEAD == 0) ? SLOT_SHOW : SLOT_DEAD;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  slot_state_e         state_q, state_d;
  logic [4*DIGITS-1:0] shd_q, shd_d;
  logic [4*DIGITS-1:0] dsp_q, dsp_d;
  logic [3:0]          nibble_d;
  logic [DIGITS-1:0]   dig_d;
  logic                dp_d;
  logic [DIGITS-1:0]   blanked;
  logic                all_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= SLOT_START;
      shd_q    <= '0;
      dsp_q    <= '0;
      nibble_o <= '0;
      dig_o    <= '0;
      dp_o     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      shd_q    <= shd_d;
      dsp_q    <= dsp_d;
      nibble_o <= nibble_d;
      dig_o    <= dig_d;
      dp_o     <= dp_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    state_d = state_q;
    shd_d   = load_i ? data_i : shd_q;
    dsp_d   = dsp_q;

    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = SLOT_START;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        // Frame boundary: a same-cycle load bypasses the shadow so it is not lost.
        dsp_d = shd_d;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else if (DEAD != 0 && cnt_q == DEAD_LAST) begin
      state_d = SLOT_SHOW;
    end
  end

  always_comb begin
    all_zero = 1'b1;
    blanked  = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      all_zero   = all_zero & (dsp_q[4*k +: 4] == 4'h0);
      blanked[k] = blank_lz_i & all_zero;
    end

    nibble_d = dsp_q[{idx_q, 2'b00} +: 4];
    dp_d     = (state_q == SLOT_SHOW) & dp_i[idx_q];
    dig_d    = '0;
    if (state_q == SLOT_SHOW && !blanked[idx_q]) begin
      dig_d = DIGITS'(1) << idx_q;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised and directed check of seg_scan against a frame-level reference model.
module tb_seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 8;
  localparam int DEAD   = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] data_i;
  logic        load_i;
  logic        blank_lz_i;
  logic [3:0]  dp_i;
  logic [3:0]  nibble_o;
  logic [3:0]  dig_o;
  logic        dp_o;

  seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .dp_i       (dp_i),
    .nibble_o   (nibble_o),
    .dig_o      (dig_o),
    .dp_o       (dp_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: n counts clock edges since the last reset; slot position and digit follow from it.
  int          n = 0;
  logic [15:0] m_shd = '0;
  logic [15:0] m_dsp = '0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit lz_blank(input logic [15:0] v, input int k, input bit en);
    if (!en || k == 0) return 1'b0;
    return (v >> (4 * k)) == 16'h0;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    int         pos;
    int         dg;
    logic [3:0] e_nib;
    logic [3:0] e_dig;
    logic [3:0] e_dp;
    pos = n % DIV;
    dg  = (n / DIV) % DIGITS;
    if (rst_i) begin
      e_nib = 4'h0;
      e_dig = 4'h0;
      e_dp  = 4'h0;
    end else begin
      e_nib = m_dsp[dg*4 +: 4];
      e_dp  = {3'b000, (pos >= DEAD) && dp_i[dg]};
      e_dig = (pos >= DEAD && !lz_blank(m_dsp, dg, blank_lz_i)) ? 4'(1 << dg) : 4'h0;
    end
    @(posedge clk_i);
    if (rst_i) begin
      n     = 0;
      m_shd = '0;
      m_dsp = '0;
    end else begin
      if (load_i) m_shd = data_i;
      if (pos == DIV - 1 && dg == DIGITS - 1) m_dsp = m_shd;
      n++;
    end
    #1;
    check("nibble_o", nibble_o, e_nib);
    check("dig_o", dig_o, e_dig);
    check("dp_o", {3'b000, dp_o}, e_dp);
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic run_until(input int pos, input int dg);
    for (int i = 0; i < 2 * DIGITS * DIV; i++) begin
      if (n % DIV == pos && (n / DIV) % DIGITS == dg) break;
      step();
    end
  endtask

  task automatic load(input logic [15:0] v);
    data_i = v;
    load_i = 1'b1;
    step();
    load_i = 1'b0;
    data_i = $urandom;
  endtask

  initial begin
    rst_i      = 1'b1;
    load_i     = 1'b0;
    data_i     = 16'h0;
    blank_lz_i = 1'b0;
    dp_i       = 4'h0;

    // Reset held, then first slot after release.
    run(3);
    rst_i = 1'b0;
    run(DIV);

    // Scan order over two full frames.
    load(16'h12A4);
    run(3 * DIGITS * DIV);

    // Leading-zero blanking on and off.
    blank_lz_i = 1'b1;
    load(16'h0050);
    run(2 * DIGITS * DIV);
    blank_lz_i = 1'b0;
    run(DIGITS * DIV);

    // Mid-frame load must not tear the current frame.
    load(16'h1111);
    run(2 * DIGITS * DIV);
    run_until(3, 2);
    load(16'h2222);
    run(2 * DIGITS * DIV);

    // Load exactly on the frame boundary overrides a pending shadow value.
    run_until(0, 1);
    load(16'h4444);
    run_until(DIV - 1, DIGITS - 1);
    load(16'h3333);
    run(DIGITS * DIV + 4);

    // Reset during digit 2 SHOW, then decimal point on digit 2 only.
    run_until(4, 2);
    rst_i = 1'b1;
    data_i = 16'h9999;
    load_i = 1'b1;
    step();
    rst_i  = 1'b0;
    load_i = 1'b0;
    dp_i   = 4'b0100;
    run(2 * DIGITS * DIV);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst_i      = ($urandom_range(0, 299) == 0);
      load_i     = ($urandom_range(0, 15) == 0);
      data_i     = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      if ($urandom_range(0, 63) == 0) blank_lz_i = ~blank_lz_i;
      dp_i       = 4'($urandom);
      step();
    end
    rst_i  = 1'b0;
    load_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
